// File: rtl/csi_tx_pkt_ctrl.sv
// CSI-2 transmit packet sequencer for one D-PHY data lane (8-bit PPI, HS only).
// Emits header, FIFO payload and CRC-16 footer over the PPI HS request/ready handshake.
module csi_tx_pkt_ctrl #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned HS_GAP = 4
) (
    input  logic             csi_clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic             start,
    input  logic [7:0]       cfg_di,
    input  logic [15:0]      cfg_wc,
    input  logic [7:0]       cfg_ecc,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_rd,
    output logic             tx_request_hs,
    input  logic             tx_ready_hs,
    output logic [7:0]       tx_data_hs,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    output logic [CNT_W-1:0] pkt_cnt
);

    localparam logic [7:0] GapLast = 8'(HS_GAP - 1);

    typedef enum logic [2:0] {StIdle, StHdr, StPay, StCrc, StGap} state_e;

    state_e           state_q, state_d;
    logic [7:0]       di_q, di_d;
    logic [15:0]      wc_q, wc_d;
    logic [7:0]       ecc_q, ecc_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      pay_cnt_q, pay_cnt_d;
    logic [15:0]      crc_q, crc_d;
    logic [7:0]       gap_q, gap_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [7:0]       pay_byte;
    logic             is_short;

    // CCITT CRC-16, reflected polynomial, one byte LSB-first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    assign is_short = (di_q[5:0] < 6'h10);
    assign pay_byte = fifo_empty ? 8'h00 : fifo_data;
    assign pkt_cnt  = pkt_cnt_q;

    always_ff @(posedge csi_clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            di_q      <= 8'h00;
            wc_q      <= 16'h0000;
            ecc_q     <= 8'h00;
            idx_q     <= 2'd0;
            pay_cnt_q <= 16'h0000;
            crc_q     <= 16'hFFFF;
            gap_q     <= 8'h00;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            di_q      <= di_d;
            wc_q      <= wc_d;
            ecc_q     <= ecc_d;
            idx_q     <= idx_d;
            pay_cnt_q <= pay_cnt_d;
            crc_q     <= crc_d;
            gap_q     <= gap_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        di_d          = di_q;
        wc_d          = wc_q;
        ecc_d         = ecc_q;
        idx_d         = idx_q;
        pay_cnt_d     = pay_cnt_q;
        crc_d         = crc_q;
        gap_d         = gap_q;
        pkt_cnt_d     = pkt_cnt_q;
        tx_request_hs = 1'b0;
        tx_data_hs    = 8'h00;
        fifo_rd       = 1'b0;
        underrun      = 1'b0;
        done          = 1'b0;
        busy          = (state_q != StIdle);

        case (state_q)
            StIdle: begin
                if (start && cfg_en) begin
                    di_d      = cfg_di;
                    wc_d      = cfg_wc;
                    ecc_d     = cfg_ecc;
                    idx_d     = 2'd0;
                    pay_cnt_d = 16'h0000;
                    crc_d     = 16'hFFFF;
                    state_d   = StHdr;
                end
            end
            StHdr: begin
                tx_request_hs = 1'b1;
                case (idx_q)
                    2'd0:    tx_data_hs = di_q;
                    2'd1:    tx_data_hs = wc_q[7:0];
                    2'd2:    tx_data_hs = wc_q[15:8];
                    default: tx_data_hs = ecc_q;
                endcase
                if (tx_ready_hs) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        idx_d = 2'd0;
                        if (is_short) begin
                            gap_d   = 8'h00;
                            state_d = StGap;
                        end else if (wc_q == 16'h0000) begin
                            state_d = StCrc;
                        end else begin
                            state_d = StPay;
                        end
                    end
                end
            end
            StPay: begin
                tx_request_hs = 1'b1;
                tx_data_hs    = pay_byte;
                fifo_rd       = tx_ready_hs && !fifo_empty;
                // An empty FIFO still yields a counted, CRC-covered 0x00 byte.
                underrun      = tx_ready_hs && fifo_empty;
                if (tx_ready_hs) begin
                    crc_d     = crc16_byte(crc_q, pay_byte);
                    pay_cnt_d = pay_cnt_q + 16'd1;
                    if (pay_cnt_q == wc_q - 16'd1) begin
                        state_d = StCrc;
                    end
                end
            end
            StCrc: begin
                tx_request_hs = 1'b1;
                tx_data_hs    = idx_q[0] ? crc_q[15:8] : crc_q[7:0];
                if (tx_ready_hs) begin
                    if (idx_q[0]) begin
                        idx_d   = 2'd0;
                        gap_d   = 8'h00;
                        state_d = StGap;
                    end else begin
                        idx_d = 2'd1;
                    end
                end
            end
            StGap: begin
                if (gap_q == 8'h00) begin
                    done      = 1'b1;
                    pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                end
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_csi_tx_pkt_ctrl.sv
// Bench for csi_tx_pkt_ctrl: per-cycle comparison against a packet-level byte-stream model,
// plus literal expectations for the directed packets.
module tb_csi_tx_pkt_ctrl;

    localparam int unsigned CNT_W  = 2;
    localparam int unsigned HS_GAP = 4;

    logic             csi_clk;
    logic             rst;
    logic             cfg_en;
    logic             start;
    logic [7:0]       cfg_di;
    logic [15:0]      cfg_wc;
    logic [7:0]       cfg_ecc;
    logic             fifo_empty;
    logic [7:0]       fifo_data;
    logic             fifo_rd;
    logic             tx_request_hs;
    logic             tx_ready_hs;
    logic [7:0]       tx_data_hs;
    logic             busy;
    logic             done;
    logic             underrun;
    logic [CNT_W-1:0] pkt_cnt;

    csi_tx_pkt_ctrl #(
        .CNT_W (CNT_W),
        .HS_GAP(HS_GAP)
    ) dut (
        .csi_clk      (csi_clk),
        .rst          (rst),
        .cfg_en       (cfg_en),
        .start        (start),
        .cfg_di       (cfg_di),
        .cfg_wc       (cfg_wc),
        .cfg_ecc      (cfg_ecc),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_rd      (fifo_rd),
        .tx_request_hs(tx_request_hs),
        .tx_ready_hs  (tx_ready_hs),
        .tx_data_hs   (tx_data_hs),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun),
        .pkt_cnt      (pkt_cnt)
    );

    initial csi_clk = 1'b0;
    always #5 csi_clk = ~csi_clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [7:0]  exp_q[$];
    logic [7:0]  fifo_src[$];
    logic [63:0] hole_mask;
    int          byte_idx;
    int          m_wc;
    bit          m_long;
    bit          m_active;
    int          gap_left;
    int          m_cnt;
    // Observed per-packet statistics
    logic [7:0]  sent_q[$];
    int          pops, unds, req_cycles;
    bit          rdy_rand;
    bit          ip, exp_rd, exp_und;
    logic [7:0]  drop;

    task automatic check(input string name, input bit ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_eq(input string name, input int act, input int exp);
        check(name, act == exp, act, exp);
    endtask

    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[0] ^ b[k];
            r  = r >> 1;
            if (fb) r = r ^ 16'h8408;
        end
        return r;
    endfunction

    // Whole expected byte stream for the packet being started, from current cfg and FIFO.
    function automatic void build();
        logic [7:0]  src[$];
        logic [15:0] c;
        logic [7:0]  b;
        exp_q.delete();
        exp_q.push_back(cfg_di);
        exp_q.push_back(cfg_wc[7:0]);
        exp_q.push_back(cfg_wc[15:8]);
        exp_q.push_back(cfg_ecc);
        m_long = (cfg_di[5:0] >= 6'h10);
        m_wc   = m_long ? int'(cfg_wc) : 0;
        if (m_long) begin
            src = fifo_src;
            c   = 16'hFFFF;
            for (int i = 0; i < m_wc; i++) begin
                if ((i < 64 && hole_mask[i[5:0]]) || src.size() == 0) b = 8'h00;
                else b = src.pop_front();
                c = crc_model(c, b);
                exp_q.push_back(b);
            end
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
        end
    endfunction

    function automatic bit in_pay();
        return m_active && m_long && byte_idx >= 4 && byte_idx < 4 + m_wc;
    endfunction

    function automatic void refresh_fifo();
        fifo_empty = (fifo_src.size() == 0) || (in_pay() && hole_mask[6'(byte_idx - 4)]);
        fifo_data  = fifo_empty ? 8'hEE : fifo_src[0];
    endfunction

    // Per-cycle comparison and model advance, sampled on the falling edge.
    initial begin : compare
        forever begin
            @(negedge csi_clk);
            if (!rst) begin
                m_active = 1'b0;
                gap_left = 0;
                m_cnt    = 0;
                byte_idx = 0;
                exp_q.delete();
                chk_eq("rst_request", int'(tx_request_hs), 0);
                chk_eq("rst_busy", int'(busy), 0);
                chk_eq("rst_done", int'(done), 0);
                chk_eq("rst_fifo_rd", int'(fifo_rd), 0);
                chk_eq("rst_underrun", int'(underrun), 0);
                chk_eq("rst_pkt_cnt", int'(pkt_cnt), 0);
            end else begin
                ip      = in_pay();
                exp_rd  = ip && tx_ready_hs && !fifo_empty;
                exp_und = ip && tx_ready_hs && fifo_empty;
                chk_eq("request", int'(tx_request_hs), int'(m_active));
                chk_eq("busy", int'(busy), int'(m_active || gap_left > 0));
                chk_eq("done", int'(done), int'(gap_left == int'(HS_GAP)));
                chk_eq("pkt_cnt", int'(pkt_cnt), m_cnt);
                chk_eq("fifo_rd", int'(fifo_rd), int'(exp_rd));
                chk_eq("underrun", int'(underrun), int'(exp_und));
                if (m_active && exp_q.size() > 0)
                    chk_eq("tx_data", int'(tx_data_hs), int'(exp_q[0]));
                if (tx_request_hs) req_cycles++;
                if (tx_request_hs && tx_ready_hs) sent_q.push_back(tx_data_hs);
                if (fifo_rd) pops++;
                if (underrun) unds++;
                if (m_active) begin
                    if (tx_ready_hs) begin
                        drop = exp_q.pop_front();
                        if (exp_rd) drop = fifo_src.pop_front();
                        byte_idx++;
                        if (exp_q.size() == 0) begin
                            m_active = 1'b0;
                            gap_left = int'(HS_GAP);
                        end
                    end
                end else if (gap_left > 0) begin
                    if (gap_left == int'(HS_GAP)) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    gap_left--;
                end else if (start && cfg_en) begin
                    build();
                    m_active   = 1'b1;
                    byte_idx   = 0;
                    sent_q.delete();
                    pops       = 0;
                    unds       = 0;
                    req_cycles = 0;
                end
            end
            @(posedge csi_clk);
            #1;
            refresh_fifo();
        end
    end

    initial begin : ready_drv
        tx_ready_hs = 1'b1;
        forever begin
            @(posedge csi_clk);
            #1;
            tx_ready_hs = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic pulse_start(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
        @(posedge csi_clk);
        #1;
        cfg_di  = di;
        cfg_wc  = wc;
        cfg_ecc = ecc;
        start   = 1'b1;
        @(posedge csi_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge csi_clk);
            n++;
        end
        check("idle_timeout", n < budget, n, budget);
        @(negedge csi_clk);
    endtask

    task automatic load_crc_vector();
        logic [7:0] v[24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                              8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                              8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
        fifo_src.delete();
        foreach (v[i]) fifo_src.push_back(v[i]);
        refresh_fifo();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int rises, low, gap, n, busy_seen;
        bit prev;
        rst = 1'b0; cfg_en = 1'b0; start = 1'b0; cfg_di = 8'h00; cfg_wc = 16'h0000;
        cfg_ecc = 8'h00; rdy_rand = 1'b0; hole_mask = 64'h0; fifo_empty = 1'b1;
        fifo_data = 8'hEE; m_cnt = 0; m_active = 1'b0; gap_left = 0; byte_idx = 0;
        pops = 0; unds = 0; req_cycles = 0;
        repeat (2) @(posedge csi_clk);
        #1;
        rst    = 1'b1;
        cfg_en = 1'b1;
        @(negedge csi_clk);
        chk_eq("init_pkt_cnt", int'(pkt_cnt), 0);

        // Short packet
        pulse_start(8'h00, 16'h1234, 8'h2B);
        wait_idle(50);
        chk_eq("short_len", sent_q.size(), 4);
        if (sent_q.size() == 4) begin
            chk_eq("short_b0", int'(sent_q[0]), 'h00);
            chk_eq("short_b1", int'(sent_q[1]), 'h34);
            chk_eq("short_b2", int'(sent_q[2]), 'h12);
            chk_eq("short_b3", int'(sent_q[3]), 'h2B);
        end
        chk_eq("short_req_cycles", req_cycles, 4);
        chk_eq("short_pops", pops, 0);
        chk_eq("short_pkt_cnt", int'(pkt_cnt), 1);

        // Long packet with known CRC; cfg change and start while busy must not matter
        load_crc_vector();
        pulse_start(8'h2A, 16'd24, 8'h1C);
        repeat (6) @(posedge csi_clk);
        #1;
        cfg_di = 8'h3F; cfg_wc = 16'd3; cfg_ecc = 8'h99; start = 1'b1;
        @(posedge csi_clk);
        #1;
        start = 1'b0;
        wait_idle(100);
        chk_eq("crc_len", sent_q.size(), 30);
        if (sent_q.size() == 30) begin
            chk_eq("crc_lo", int'(sent_q[28]), 'hF0);
            chk_eq("crc_hi", int'(sent_q[29]), 'h00);
        end
        chk_eq("crc_pops", pops, 24);
        chk_eq("crc_pkt_cnt", int'(pkt_cnt), 2);

        // Long packet, zero word count
        pulse_start(8'h2A, 16'd0, 8'h55);
        wait_idle(50);
        chk_eq("wc0_len", sent_q.size(), 6);
        if (sent_q.size() == 6) begin
            chk_eq("wc0_crc_lo", int'(sent_q[4]), 'hFF);
            chk_eq("wc0_crc_hi", int'(sent_q[5]), 'hFF);
        end
        chk_eq("wc0_pops", pops, 0);

        // Backpressure, FIFO holes at payload bytes 3-4, cfg_en dropped mid-packet
        fifo_src.delete();
        fifo_src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        hole_mask = 64'h18;
        refresh_fifo();
        rdy_rand = 1'b1;
        pulse_start(8'h2A, 16'd8, 8'h21);
        repeat (3) @(posedge csi_clk);
        #1;
        cfg_en = 1'b0;
        wait_idle(300);
        rdy_rand  = 1'b0;
        cfg_en    = 1'b1;
        hole_mask = 64'h0;
        chk_eq("bp_underruns", unds, 2);
        chk_eq("bp_pops", pops, 6);
        if (sent_q.size() == 14) begin
            chk_eq("bp_pay3", int'(sent_q[7]), 'h00);
            chk_eq("bp_pay4", int'(sent_q[8]), 'h00);
            chk_eq("bp_pay5", int'(sent_q[9]), 'h44);
        end else begin
            chk_eq("bp_len", sent_q.size(), 14);
        end
        chk_eq("wrap_pkt_cnt", int'(pkt_cnt), 0);

        // Reset in the middle of the payload
        load_crc_vector();
        pulse_start(8'h2A, 16'd24, 8'h1C);
        repeat (8) @(posedge csi_clk);
        #3;
        rst = 1'b0;
        #1;
        chk_eq("rst_req_drop", int'(tx_request_hs), 0);
        chk_eq("rst_busy_drop", int'(busy), 0);
        @(posedge csi_clk);
        #3;
        rst = 1'b1;
        @(negedge csi_clk);
        chk_eq("rst_pkt_cnt_kept", int'(pkt_cnt), 0);
        load_crc_vector();
        pulse_start(8'h2A, 16'd24, 8'h1C);
        wait_idle(100);
        if (sent_q.size() == 30) begin
            chk_eq("post_rst_crc_lo", int'(sent_q[28]), 'hF0);
            chk_eq("post_rst_crc_hi", int'(sent_q[29]), 'h00);
        end else begin
            chk_eq("post_rst_len", sent_q.size(), 30);
        end
        chk_eq("post_rst_pkt_cnt", int'(pkt_cnt), 1);

        // Start with controller disabled
        cfg_en = 1'b0;
        pulse_start(8'h01, 16'h0001, 8'h00);
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge csi_clk);
            if (busy || tx_request_hs) busy_seen++;
        end
        chk_eq("disabled_busy", busy_seen, 0);
        cfg_en = 1'b1;

        // Back-to-back starts: start held high across two packets
        @(posedge csi_clk);
        #1;
        cfg_di = 8'h01; cfg_wc = 16'hABCD; cfg_ecc = 8'h3C; start = 1'b1;
        rises = 0; low = 0; gap = 0; n = 0; prev = 1'b0;
        while (rises < 2 && n < 100) begin
            @(negedge csi_clk);
            n++;
            if (tx_request_hs && !prev) begin
                rises++;
                if (rises == 2) gap = low;
            end
            if (!tx_request_hs && prev) low = 0;
            if (!tx_request_hs) low++;
            prev = tx_request_hs;
        end
        @(posedge csi_clk);
        #1;
        start = 1'b0;
        chk_eq("b2b_rises", rises, 2);
        check("b2b_gap", gap >= int'(HS_GAP), gap, int'(HS_GAP));
        wait_idle(50);
        chk_eq("b2b_pkt_cnt", int'(pkt_cnt), 3);

        repeat (3) @(negedge csi_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csi_tx_pkt_ctrl.md
Name: csi_tx_pkt_ctrl

Overview:
- Transmit-side sequencer for one CSI-2 D-PHY data lane, 8-bit PPI, HS mode only.
- On a start command from the control interface, it drives the PPI HS request/ready handshake and emits one packet:
  - long packet: header, then payload bytes pulled from the payload FIFO, then CRC-16 footer;
  - short packet: header only.
- Sits between the ci config registers, the payload FIFO read port and the D-PHY PPI (appi) transmit port.

Parameters:
- CNT_W, 16, width of the transmitted-packet counter.
- HS_GAP, 4, minimum idle cycles with tx_request_hs low between packets; legal range 1..255.

Ports:
- csi_clk  in  1  sole clock.
- rst  in  1  asynchronous reset, active-low.
- cfg_en  in  1  controller enable; start is ignored while low.
- start  in  1  one-cycle request to send one packet.
- cfg_di  in  8  data identifier: VC[7:6], DT[5:0].
- cfg_wc  in  16  long packet: word count in bytes; short packet: data field.
- cfg_ecc  in  8  header ECC byte, precomputed by ci.
- fifo_empty  in  1  payload FIFO empty.
- fifo_data  in  8  FIFO head byte, first-word-fall-through.
- fifo_rd  out  1  pop FIFO head.
- tx_request_hs  out  1  PPI HS request.
- tx_ready_hs  in  1  PPI byte accepted this cycle.
- tx_data_hs  out  8  PPI HS byte.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at packet end.
- underrun  out  1  one-cycle pulse per payload byte sent while the FIFO was empty.
- pkt_cnt  out  CNT_W  packets completed; wraps to 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0, state IDLE, CRC register 0xFFFF, gap counter 0;
  - tx_request_hs drops in the same instant, including mid-packet; the partial packet is abandoned and pkt_cnt is not incremented.
- Latch: start&&cfg_en in IDLE latches cfg_di, cfg_wc and cfg_ecc. Later cfg changes do not affect the packet in flight. start in any other state is ignored, not queued.
- Packet type: short when cfg_di[5:0] < 0x10, otherwise long.
- FSM states: IDLE, HDR, PAY, CRC, GAP.
- IDLE -> HDR (latency): start accepted in cycle N; in cycle N+1 tx_request_hs=1 and busy=1.
- Byte consumption: tx_data_hs is valid whenever tx_request_hs=1. A byte is consumed only in a cycle with tx_ready_hs=1. While ready=0, the same byte holds. tx_ready_hs is ignored while request=0.
- HDR: sends byte 0 cfg_di, byte 1 wc[7:0], byte 2 wc[15:8], byte 3 cfg_ecc. After byte 3 is consumed:
  - short packet -> GAP;
  - long packet with wc=0 -> CRC;
  - otherwise -> PAY.
- PAY: byte counter counts wc bytes.
  - fifo_rd = tx_ready_hs && !fifo_empty (combinational).
  - tx_data_hs = fifo_data, or 0x00 when fifo_empty.
  - Consuming a byte while fifo_empty pulses underrun that cycle. The byte still counts and still enters the CRC; no FIFO pop occurs.
  - -> CRC when the last byte is consumed.
- CRC:
  - Polynomial x^16+x^12+x^5+1, CCITT reflected (0x8408), LSB-first, init 0xFFFF, no final XOR.
  - Updated once per consumed payload byte; reset to 0xFFFF on each start.
  - Sends crc[7:0], then crc[15:8], each on a consumed cycle; -> GAP.
- GAP:
  - tx_request_hs=0; done=1 for the first GAP cycle; pkt_cnt increments in that same cycle (mod 2^CNT_W).
  - Stays in GAP for HS_GAP cycles, then -> IDLE. busy stays 1 through GAP.
- cfg_en falling mid-packet: the current packet completes normally.
- Word count: cfg_wc = 0xFFFF is legal (65535 payload bytes); the byte counter is 16 bits with no overflow.

Test Plan:
- Short packet: cfg_di=0x00, cfg_wc=0x1234, cfg_ecc=0x2B, ready tied 1 -> tx_data_hs 00,34,12,2B on 4 consecutive cycles; request high exactly 4 cycles; done after them; pkt_cnt=1; fifo_rd never asserted.
- Long packet, CRC check: cfg_di=0x2A, wc=24, FIFO preloaded with FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 -> 24 pops, footer bytes F0 00 (CRC 0x00F0).
- Long packet wc=0: header then footer FF FF; no fifo_rd.
- Backpressure and underrun:
  - tx_ready_hs random 50%, wc=8, FIFO empty for bytes 3-4 -> held bytes stable while ready=0; two underrun pulses; 00 sent in payload positions 3-4; exactly 6 pops.
- Protocol boundaries:
  - start while busy is ignored;
  - back-to-back starts with HS_GAP=4 -> ≥4 idle cycles between packets;
  - start with cfg_en=0 is ignored;
  - pkt_cnt wraps at CNT_W=2 after 4 packets.
- Reset mid-PAY (rst low for 1 cycle) -> tx_request_hs low immediately; pkt_cnt unchanged; next packet correct, with CRC starting from 0xFFFF.
